// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed N-digit seven-segment scanner with per-slot anti-ghosting guard
// and a double-buffered digit store that only swaps at frame boundaries.
module seven_segment_scan_driver #(
    parameter  int DIGITS      = 4,
    parameter  int REFRESH_DIV = 100000,
    parameter  int GUARD       = 500,
    localparam int IDX_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  enable_i,
    input  logic                  load_i,
    input  logic [4*DIGITS-1:0]   digit_data_i,
    input  logic [DIGITS-1:0]     digit_blank_i,
    input  logic [DIGITS-1:0]     dp_mask_i,
    output logic [DIGITS-1:0]     an_o,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic [IDX_W-1:0]      scan_idx_o,
    output logic                  frame_tick_o
);

    localparam int               CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_V  = CNT_W'(GUARD);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                pending_q, pending_d;
    logic [4*DIGITS-1:0] shadow_data_q, shadow_data_d;
    logic [DIGITS-1:0]   shadow_blank_q, shadow_blank_d;
    logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [4*DIGITS-1:0] disp_data_q, disp_data_d;
    logic [DIGITS-1:0]   disp_blank_q, disp_blank_d;
    logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [IDX_W-1:0]    scan_idx_q, scan_idx_d;
    logic                frame_tick_q, frame_tick_d;
    logic                frame_end;
    logic                lit;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'h0: decode = 7'h40;  4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;  4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;  4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;  4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;  4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;  4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;  4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;  default: decode = 7'h0E;
        endcase
    endfunction

    always_comb begin
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        pending_d      = pending_q;
        shadow_data_d  = shadow_data_q;
        shadow_blank_d = shadow_blank_q;
        shadow_dp_d    = shadow_dp_q;
        disp_data_d    = disp_data_q;
        disp_blank_d   = disp_blank_q;
        disp_dp_d      = disp_dp_q;

        frame_end = enable_i && (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);

        if (enable_i) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // A load landing exactly on the boundary bypasses the shadow.
        frame_tick_d = frame_end && (pending_q || load_i);
        if (frame_end) begin
            pending_d = 1'b0;
            if (load_i) begin
                disp_data_d  = digit_data_i;
                disp_blank_d = digit_blank_i;
                disp_dp_d    = dp_mask_i;
            end else if (pending_q) begin
                disp_data_d  = shadow_data_q;
                disp_blank_d = shadow_blank_q;
                disp_dp_d    = shadow_dp_q;
            end
        end else if (load_i) begin
            shadow_data_d  = digit_data_i;
            shadow_blank_d = digit_blank_i;
            shadow_dp_d    = dp_mask_i;
            pending_d      = 1'b1;
        end

        lit        = enable_i && (cnt_q >= GUARD_V) && !disp_blank_q[idx_q];
        an_d       = '1;
        seg_d      = 7'h7F;
        dp_d       = 1'b1;
        scan_idx_d = idx_q;
        if (lit) begin
            an_d  = ~(DIGITS'(1) << idx_q);
            seg_d = decode(disp_data_q[4*idx_q +: 4]);
            dp_d  = ~disp_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q          <= '0;
            idx_q          <= '0;
            pending_q      <= 1'b0;
            shadow_data_q  <= '0;
            shadow_blank_q <= '0;
            shadow_dp_q    <= '0;
            disp_data_q    <= '0;
            disp_blank_q   <= '0;
            disp_dp_q      <= '0;
            an_q           <= '1;
            seg_q          <= 7'h7F;
            dp_q           <= 1'b1;
            scan_idx_q     <= '0;
            frame_tick_q   <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            pending_q      <= pending_d;
            shadow_data_q  <= shadow_data_d;
            shadow_blank_q <= shadow_blank_d;
            shadow_dp_q    <= shadow_dp_d;
            disp_data_q    <= disp_data_d;
            disp_blank_q   <= disp_blank_d;
            disp_dp_q      <= disp_dp_d;
            an_q           <= an_d;
            seg_q          <= seg_d;
            dp_q           <= dp_d;
            scan_idx_q     <= scan_idx_d;
            frame_tick_q   <= frame_tick_d;
        end
    end

    assign an_o         = an_q;
    assign seg_o        = seg_q;
    assign dp_o         = dp_q;
    assign scan_idx_o   = scan_idx_q;
    assign frame_tick_o = frame_tick_q;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Bench for seven_segment_scan_driver: directed frame scenarios with literal
// expectations, then randomized traffic against a per-cycle behavioural model.
module tb_seven_segment_scan_driver;

    localparam int D  = 4;
    localparam int RD = 4;
    localparam int G  = 1;

    logic        clk = 1'b0;
    logic        reset, enable, load;
    logic [15:0] data;
    logic [3:0]  blank, dpm;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  sidx;
    logic        tick;

    int tests = 0;
    int fails = 0;

    seven_segment_scan_driver #(.DIGITS(D), .REFRESH_DIV(RD), .GUARD(G)) dut (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .load_i(load),
        .digit_data_i(data), .digit_blank_i(blank), .dp_mask_i(dpm),
        .an_o(an), .seg_o(seg), .dp_o(dp), .scan_idx_o(sidx), .frame_tick_o(tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic go(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_lit(input string name, input logic [3:0] e_an_l, input logic [6:0] e_seg_l);
        chk({name, "_an"}, an, e_an_l);
        chk({name, "_seg"}, seg, e_seg_l);
    endtask

    // ---------------- behavioural model ----------------
    bit [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int       m_cnt, m_idx;
    bit       m_pend;
    bit [3:0] sh_d [D], bf_d [D];
    bit       sh_b [D], bf_b [D], sh_p [D], bf_p [D];
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_tick;
    int         e_idx;
    bit         mvalid = 1'b0;
    bit         boundary;

    always @(posedge clk) begin
        if (reset) begin
            m_cnt = 0; m_idx = 0; m_pend = 1'b0;
            for (int k = 0; k < D; k++) begin
                sh_d[k] = 0; bf_d[k] = 0; sh_b[k] = 0; bf_b[k] = 0; sh_p[k] = 0; bf_p[k] = 0;
            end
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_idx = 0; e_tick = 1'b0;
            mvalid = 1'b1;
        end else begin
            if (!enable || m_cnt < G || bf_b[m_idx]) begin
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end else begin
                e_an  = 4'hF ^ (4'h1 << m_idx);
                e_seg = seg_tab[bf_d[m_idx]];
                e_dp  = !bf_p[m_idx];
            end
            e_idx    = m_idx;
            boundary = enable && m_cnt == RD - 1 && m_idx == D - 1;
            e_tick   = boundary && (m_pend || load);
            if (boundary) begin
                for (int k = 0; k < D; k++) begin
                    if (load) begin
                        bf_d[k] = data[4*k +: 4]; bf_b[k] = blank[k]; bf_p[k] = dpm[k];
                    end else if (m_pend) begin
                        bf_d[k] = sh_d[k]; bf_b[k] = sh_b[k]; bf_p[k] = sh_p[k];
                    end
                end
                m_pend = 1'b0;
            end else if (load) begin
                for (int k = 0; k < D; k++) begin
                    sh_d[k] = data[4*k +: 4]; sh_b[k] = blank[k]; sh_p[k] = dpm[k];
                end
                m_pend = 1'b1;
            end
            if (enable) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == RD) begin
                    m_cnt = 0;
                    m_idx = (m_idx + 1) % D;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("model_an", an, e_an);
            chk("model_seg", seg, e_seg);
            chk("model_dp", dp, e_dp);
            chk("model_scan_idx", sidx, e_idx[1:0]);
            chk("model_frame_tick", tick, e_tick);
        end
    end

    // ---------------- stimulus ----------------
    int got;
    int nticks;

    initial begin
        reset = 1'b1; enable = 1'b0; load = 1'b0;
        data = '0; blank = '0; dpm = '0;
        go(3);
        chk("reset_an", an, 4'hF);
        chk("reset_seg", seg, 7'h7F);
        chk("reset_dp", dp, 1'b1);
        chk("reset_idx", sidx, 2'd0);
        chk("reset_tick", tick, 1'b0);

        reset = 1'b0; enable = 1'b1; load = 1'b1; data = 16'h3210;
        go(1); load = 1'b0;
        chk("first_guard_an", an, 4'hF);
        go(1);
        chk_lit("frame0_d0", 4'hE, 7'h40);

        got = 0;
        for (int i = 0; i < 40 && got == 0; i++) begin
            go(1);
            if (tick === 1'b1) got = 1;
        end
        chk("first_tick_seen", got, 1);

        // frame 1 shows 3210; FEDC loaded mid-frame at idx 1
        go(2);  chk_lit("f1_d0", 4'hE, 7'h40);
        go(4);  chk_lit("f1_d1", 4'hD, 7'h79);
        load = 1'b1; data = 16'hFEDC;
        go(1);  load = 1'b0;
        go(3);  chk_lit("tear_d2_old", 4'hB, 7'h24);
        go(4);  chk_lit("tear_d3_old", 4'h7, 7'h30);
        go(2);  chk("tear_tick", tick, 1'b1);
        go(2);  chk_lit("f2_d0", 4'hE, 7'h46);
        load = 1'b1; data = 16'h1111;
        go(1);  data = 16'h2222;
        go(1);  load = 1'b0;
        go(2);  chk_lit("f2_d1", 4'hD, 7'h21);
        go(4);  chk_lit("f2_d2", 4'hB, 7'h06);
        go(4);  chk_lit("f2_d3", 4'h7, 7'h0E);
        go(1);  load = 1'b1; data = 16'h8888;
        go(1);  load = 1'b0;
        chk("bypass_tick", tick, 1'b1);
        go(2);  chk_lit("f3_d0", 4'hE, 7'h00);
        go(4);  chk_lit("f3_d1", 4'hD, 7'h00);
        go(4);  chk_lit("f3_d2", 4'hB, 7'h00);
        go(4);  chk_lit("f3_d3", 4'h7, 7'h00);

        // blank digit 2, decimal point on digit 0
        load = 1'b1; data = 16'h3210; blank = 4'b0100; dpm = 4'b0001;
        go(1);  load = 1'b0;
        go(1);  chk("blank_tick", tick, 1'b1);
        go(2);  chk_lit("f4_d0", 4'hE, 7'h40); chk("f4_d0_dp", dp, 1'b0);
        go(4);  chk_lit("f4_d1", 4'hD, 7'h79); chk("f4_d1_dp", dp, 1'b1);
        go(4);  chk_lit("f4_d2_blank", 4'hF, 7'h7F); chk("f4_d2_dp", dp, 1'b1);
        go(4);  chk_lit("f4_d3", 4'h7, 7'h30); chk("f4_d3_dp", dp, 1'b1);
        load = 1'b1; blank = 4'b0000; dpm = 4'b0000;
        go(1);  load = 1'b0;
        go(1);  chk("f5_tick", tick, 1'b1);

        // freeze at idx 2, cnt 2
        go(10); chk_lit("pre_freeze", 4'hB, 7'h24);
        enable = 1'b0;
        go(1);  chk("freeze_an", an, 4'hF); chk("freeze_idx", sidx, 2'd2);
        go(3);  chk("frozen_an", an, 4'hF); chk("frozen_idx", sidx, 2'd2);
        enable = 1'b1;
        go(1);  chk_lit("resume_cnt2", 4'hB, 7'h24); chk("resume_idx", sidx, 2'd2);
        go(1);  chk_lit("resume_cnt3", 4'hB, 7'h24);
        go(1);  chk("resume_next_an", an, 4'hF); chk("resume_next_idx", sidx, 2'd3);

        // reset with a pending load
        load = 1'b1; data = 16'h8888;
        go(1);  load = 1'b0; reset = 1'b1;
        go(1);
        chk("rst_mid_an", an, 4'hF);
        chk("rst_mid_seg", seg, 7'h7F);
        chk("rst_mid_idx", sidx, 2'd0);
        chk("rst_mid_tick", tick, 1'b0);
        go(2);  reset = 1'b0;
        nticks = 0;
        for (int i = 1; i <= 40; i++) begin
            go(1);
            if (tick === 1'b1) nticks++;
            if (i == 2)  chk_lit("post_rst_d0", 4'hE, 7'h40);
            if (i == 18) chk_lit("post_rst_f1_d0", 4'hE, 7'h40);
        end
        chk("post_rst_no_tick", nticks, 0);

        // randomized traffic, checked by the model every cycle
        for (int i = 0; i < 2500; i++) begin
            reset  = ($urandom_range(0, 199) == 0);
            enable = ($urandom_range(0, 9) != 0);
            load   = ($urandom_range(0, 7) == 0);
            data   = 16'($urandom);
            blank  = 4'($urandom);
            dpm    = 4'($urandom);
            go(1);
        end
        reset = 1'b0; load = 1'b0;
        go(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
